ofm_writeback_ctrl: RTL and testbench

- Opposite-direction counterpart of the global load controller.
- The load controller moves weights/IFM from global BRAM into fused BRAM. This block drains computed OFM words from fused BRAM and writes them back to global BRAM.
- It issues sequential fused-BRAM reads, absorbs the fixed read latency in a small skid FIFO, and presents writes to global BRAM under a grant handshake from the global-BRAM arbiter.

---
 rtl/fused_ctrl_pkg.sv | 24 ++
 rtl/wb_skid_fifo.sv | 57 +++++
 rtl/ofm_writeback_ctrl.sv | 147 ++++++++++++++
 tb/tb_ofm_writeback_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fused_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fused_ctrl_pkg : shared controller state encoding and load-control codes
// Revision: 1.0
// ---------------------------------------------------------------------------
package fused_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ADDR_STEP_DEFAULT = 4;

    // Encodings used by the companion global load controller.
    typedef enum logic [1:0] {
        NO_LOAD       = 2'd0,
        LOAD_IFM_C    = 2'd1,
        LOAD_WEIGHT_C = 2'd2
    } control_load_t;

endpackage
`default_nettype wire

// File: rtl/wb_skid_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_skid_fifo : small synchronous FIFO absorbing fused-BRAM read latency
// Revision: 1.0
// ---------------------------------------------------------------------------
module wb_skid_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);

endmodule
`default_nettype wire

// File: rtl/ofm_writeback_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ofm_writeback_ctrl : drains OFM words from fused BRAM into global BRAM
// Revision: 1.0
// ---------------------------------------------------------------------------
module ofm_writeback_ctrl
    import fused_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int ADDR_STEP  = ADDR_STEP_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr_OFM,
    input  logic [ADDR_W-1:0] base_addr_fused,
    input  logic [31:0]       size_OFM,
    output logic [ADDR_W-1:0] rd_addr_fused,
    output logic              re_fused,
    input  logic [DATA_W-1:0] rd_data_fused,
    output logic [ADDR_W-1:0] wr_addr_global,
    output logic [DATA_W-1:0] wr_data_global,
    output logic              we_global,
    input  logic              global_gnt,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t            state;
    logic [31:0]       size_q;
    logic [31:0]       rd_cnt;
    logic [31:0]       wr_cnt;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [RD_LAT-1:0] pipe;
    logic [7:0]        inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [DATA_W-1:0] head;
    logic              push;
    logic              pop;
    logic              issue;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + 8'(pipe[i]);
        end
    end

    assign push = pipe[RD_LAT-1];
    assign pop  = !fifo_empty && global_gnt;

    // Credit rule: reads in flight plus FIFO occupancy never exceed depth,
    // counting the slot freed by this cycle's pop.
    assign issue = (state == XFER) && (rd_cnt < size_q) &&
                   ((inflight + 8'(fifo_count)) < (8'(FIFO_DEPTH) + 8'(pop)));

    assign re_fused       = issue;
    assign rd_addr_fused  = rd_addr_q;
    assign we_global      = !fifo_empty;
    assign wr_data_global = fifo_empty ? '0 : head;
    assign wr_addr_global = wr_addr_q;

    wb_skid_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (rd_data_fused),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            size_q    <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            pipe      <= '0;
        end else begin
            pipe[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (issue) begin
                rd_cnt    <= rd_cnt + 32'd1;
                rd_addr_q <= rd_addr_q + ADDR_W'(ADDR_STEP);
            end
            if (pop) begin
                wr_cnt    <= wr_cnt + 32'd1;
                wr_addr_q <= wr_addr_q + ADDR_W'(ADDR_STEP);
            end
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        size_q    <= size_OFM;
                        rd_cnt    <= '0;
                        wr_cnt    <= '0;
                        rd_addr_q <= base_addr_fused;
                        wr_addr_q <= base_addr_OFM;
                        if (size_OFM != 32'd0) begin
                            state <= XFER;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (pop && (wr_cnt == size_q - 32'd1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ofm_writeback_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ofm_writeback_ctrl : directed bench for two writeback controller configs
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ofm_writeback_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        gnt;
    logic [31:0] base_o;
    logic [31:0] base_f;
    logic [31:0] size;
    logic        start_v   [2];
    logic [31:0] rd_addr_v [2];
    logic [31:0] rd_data_v [2];
    logic [31:0] wr_addr_v [2];
    logic [31:0] wr_data_v [2];
    logic        re_v      [2];
    logic        we_v      [2];
    logic        busy_v    [2];
    logic        done_v    [2];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rd_seen  [2] = '{0, 0};
    int          wr_seen  [2] = '{0, 0};
    int          snap_r   [2] = '{0, 0};
    int          snap_w   [2] = '{0, 0};
    logic        stall_q  [2] = '{1'b0, 1'b0};
    logic [31:0] hold_a   [2];
    logic [31:0] hold_d   [2];
    logic [31:0] exp_o = '0;
    logic [31:0] exp_f = '0;
    logic [31:0] s1, s2;

    always #5 clk = ~clk;

    ofm_writeback_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]),
        .base_addr_OFM(base_o), .base_addr_fused(base_f), .size_OFM(size),
        .rd_addr_fused(rd_addr_v[0]), .re_fused(re_v[0]), .rd_data_fused(rd_data_v[0]),
        .wr_addr_global(wr_addr_v[0]), .wr_data_global(wr_data_v[0]), .we_global(we_v[0]),
        .global_gnt(gnt), .busy(busy_v[0]), .done(done_v[0])
    );

    ofm_writeback_ctrl #(.RD_LAT(3), .FIFO_DEPTH(5)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]),
        .base_addr_OFM(base_o), .base_addr_fused(base_f), .size_OFM(size),
        .rd_addr_fused(rd_addr_v[1]), .re_fused(re_v[1]), .rd_data_fused(rd_data_v[1]),
        .wr_addr_global(wr_addr_v[1]), .wr_data_global(wr_data_v[1]), .we_global(we_v[1]),
        .global_gnt(gnt), .busy(busy_v[1]), .done(done_v[1])
    );

    // Fused memory content: word at byte address a is 0xA0 + a/4.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + (a >> 2);
    endfunction

    always @(posedge clk) begin
        if (re_v[0]) rd_data_v[0] <= mem_word(rd_addr_v[0]);
        if (re_v[1]) s1 <= mem_word(rd_addr_v[1]);
        s2           <= s1;
        rd_data_v[1] <= s2;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: write order/address, stability under stall, credit bound.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (stall_q[i]) begin
                chk("hold_we", {31'd0, we_v[i]}, 32'd1);
                chk("hold_addr", wr_addr_v[i], hold_a[i]);
                chk("hold_data", wr_data_v[i], hold_d[i]);
            end
            if (re_v[i] === 1'b1) rd_seen[i]++;
            if (we_v[i] === 1'b1 && gnt) begin
                chk("wr_addr", wr_addr_v[i], exp_o + 32'((wr_seen[i] - snap_w[i]) * 4));
                chk("wr_data", wr_data_v[i], mem_word(exp_f) + 32'(wr_seen[i] - snap_w[i]));
                wr_seen[i]++;
            end
            chk("credit", {31'd0, ((rd_seen[i] - snap_r[i]) - (wr_seen[i] - snap_w[i])) <= ((i == 0) ? 4 : 5)}, 32'd1);
            stall_q[i] = reset_n && (we_v[i] === 1'b1) && !gnt;
            hold_a[i]  = wr_addr_v[i];
            hold_d[i]  = wr_data_v[i];
        end
    end

    task automatic begin_test(input logic [31:0] ob, input logic [31:0] fb);
        exp_o = ob;
        exp_f = fb;
        for (int i = 0; i < 2; i++) begin
            snap_w[i] = wr_seen[i];
            snap_r[i] = rd_seen[i];
        end
    endtask

    task automatic run(input int sel, input logic [31:0] sz, input logic [31:0] ob,
                       input logic [31:0] fb, input bit toggle, input int restart_at,
                       input int exp_cyc, input int exp_first, input int exp_n);
        int cyc;
        int first_we;
        bit seen;
        begin_test(ob, fb);
        base_o = ob; base_f = fb; size = sz; gnt = 1'b1;
        start_v[sel] = 1'b1;
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        cyc = 1; first_we = 0; seen = 1'b0;
        while (cyc <= 300 && !seen) begin
            if (cyc == 1 && sz != 0) begin
                chk("first_re", {31'd0, re_v[sel]}, 32'd1);
                chk("first_rd_addr", rd_addr_v[sel], fb);
            end
            if (we_v[sel] && first_we == 0) first_we = cyc;
            if (done_v[sel]) begin
                seen = 1'b1;
            end else begin
                if (cyc == restart_at) begin
                    start_v[sel] = 1'b1;
                    base_o = 32'h3000; base_f = 32'h80; size = 32'd2;
                end else begin
                    start_v[sel] = 1'b0;
                end
                if (toggle) gnt = (cyc % 4 == 0) || (cyc % 4 == 3);
                @(posedge clk); #1;
                cyc++;
            end
        end
        start_v[sel] = 1'b0;
        chk("done_seen", {31'd0, seen}, 32'd1);
        if (exp_cyc > 0) chk("done_cycle", cyc, exp_cyc);
        if (exp_first > 0) chk("first_we_cycle", first_we, exp_first);
        chk("busy_at_done", {31'd0, busy_v[sel]}, 32'd0);
        chk("writes", wr_seen[sel] - snap_w[sel], exp_n);
        chk("reads", rd_seen[sel] - snap_r[sel], exp_n);
        gnt = 1'b1;
        @(posedge clk); #1;
        chk("done_pulse", {31'd0, done_v[sel]}, 32'd0);
        chk("idle_we", {31'd0, we_v[sel]}, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_re"},      {31'd0, re_v[0]},   32'd0);
        chk({tag, "_we"},      {31'd0, we_v[0]},   32'd0);
        chk({tag, "_busy"},    {31'd0, busy_v[0]}, 32'd0);
        chk({tag, "_done"},    {31'd0, done_v[0]}, 32'd0);
        chk({tag, "_rd_addr"}, rd_addr_v[0],       32'd0);
        chk({tag, "_wr_addr"}, wr_addr_v[0],       32'd0);
        chk({tag, "_wr_data"}, wr_data_v[0],       32'd0);
    endtask

    initial begin
        reset_n = 1'b0; gnt = 1'b1;
        base_o = '0; base_f = '0; size = '0;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        chk("reset_busy3", {31'd0, busy_v[1]}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Baseline 8-word transfer, grant always high.
        run(0, 32'd8, 32'h1000, 32'h0, 1'b0, -1, 11, 3, 8);
        // Same transfer with grant pattern 1,0,0,1.
        run(0, 32'd8, 32'h1000, 32'h0, 1'b1, -1, 0, 3, 8);
        // Zero-length transfer.
        run(0, 32'd0, 32'h1000, 32'h0, 1'b0, -1, 1, 0, 0);
        // Deep latency configuration, sustained throughput.
        run(1, 32'd16, 32'h4000, 32'h100, 1'b0, -1, 21, 5, 16);

        // Reset in the cycle of the third accepted write of a 10-word transfer.
        begin_test(32'h1000, 32'h0);
        base_o = 32'h1000; base_f = 32'h0; size = 32'd10; gnt = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_we", {31'd0, we_v[0]}, 32'd1);
        chk("pre_reset_addr", wr_addr_v[0], 32'h1008);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk_zero("midreset");
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_reset_we", {31'd0, we_v[0]}, 32'd0);
            chk("post_reset_re", {31'd0, re_v[0]}, 32'd0);
        end
        chk("reset_writes", wr_seen[0] - snap_w[0], 32'd3);
        run(0, 32'd4, 32'h2000, 32'h40, 1'b0, -1, 7, 3, 4);

        // start pulsed again while busy must be ignored.
        run(0, 32'd8, 32'h1000, 32'h0, 1'b0, 3, 11, 3, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
